// File: rtl/picorv32_mem_pkg.sv
// Shared types and constants for the picorv32 native-interface memory responder.
package picorv32_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] FAULT_RDATA = 32'hDEAD_BEEF;
    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    // Right-shift Fibonacci form of taps 16,14,13,11 (bits 0,2,3,5).
    localparam logic [15:0] LFSR_TAPS   = 16'h002D;
    // Wide enough for 15 base wait states plus up to 3 random ones.
    localparam int          WCNT_W      = 5;

    function automatic logic lfsr_fb(input logic [15:0] s);
        return ^(s & LFSR_TAPS);
    endfunction

endpackage

// File: rtl/mem_resp_lfsr.sv
// 16-bit Fibonacci LFSR used to jitter the responder's wait-state count.
module mem_resp_lfsr
    import picorv32_mem_pkg::*;
(
    input  logic        clk,
    input  logic        resetn,
    input  logic        en_i,
    output logic [15:0] lfsr_o
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = lfsr_q;
        if (en_i) lfsr_d = {lfsr_fb(lfsr_q), lfsr_q[15:1]};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) lfsr_q <= LFSR_SEED;
        else         lfsr_q <= lfsr_d;
    end

    assign lfsr_o = lfsr_q;

endmodule

// File: rtl/picorv32_mem_responder.sv
// Word-addressed RAM answering the picorv32 mem_valid/mem_ready handshake with wait states.
// Build option MEM_RESP_LFSR_WAIT_EN adds 0..3 pseudo-random extra wait states per request.
module picorv32_mem_responder
    import picorv32_mem_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             mem_valid,
    input  logic             mem_instr,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    output logic             mem_ready,
    output logic [31:0]      mem_rdata,
    output logic             fault,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count,
    output logic [CNT_W-1:0] if_count
);

    localparam int DEPTH = 2 ** ADDR_BITS;

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d, wait_load;
    logic [31:0]       addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic              instr_q, instr_d, fault_q, fault_d;
    logic [CNT_W-1:0]  rd_q, rd_d, wr_q, wr_d, if_q, if_d;
    logic [31:0]       mem_q [DEPTH];

    logic [31:0]          acc_addr, acc_wdata;
    logic [3:0]           acc_wstrb;
    logic [ADDR_BITS-1:0] acc_idx;
    logic                 acc_oob, accept, enter_resp, ram_we;
    logic                 unused_bits;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign accept = (state_q == IDLE) && mem_valid;

`ifdef MEM_RESP_LFSR_WAIT_EN
    logic [15:0] lfsr;
    logic        unused_lfsr;

    mem_resp_lfsr u_lfsr (
        .clk    (clk),
        .resetn (resetn),
        .en_i   (accept),
        .lfsr_o (lfsr)
    );

    assign wait_load   = WCNT_W'(WAIT_CYCLES) + WCNT_W'(lfsr[1:0]);
    assign unused_lfsr = ^lfsr[15:2];
`else
    assign wait_load = WCNT_W'(WAIT_CYCLES);
`endif

    // On the zero-wait path RESP is entered straight from IDLE, before the latches hold the request.
    assign acc_addr    = (state_q == IDLE) ? mem_addr  : addr_q;
    assign acc_wdata   = (state_q == IDLE) ? mem_wdata : wdata_q;
    assign acc_wstrb   = (state_q == IDLE) ? mem_wstrb : wstrb_q;
    assign acc_idx     = acc_addr[ADDR_BITS+1:2];
    assign acc_oob     = |acc_addr[31:ADDR_BITS+2];
    assign unused_bits = ^acc_addr[1:0];

    always_comb begin
        state_d    = state_q;
        wcnt_d     = wcnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        instr_d    = instr_q;
        rdata_d    = rdata_q;
        fault_d    = fault_q;
        enter_resp = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    instr_d = mem_instr;
                    wcnt_d  = wait_load;
                    if (wait_load == '0) begin
                        state_d    = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!mem_valid) begin
                    state_d = IDLE;
                    wcnt_d  = '0;
                    fault_d = 1'b1;
                end else if (wcnt_q == WCNT_W'(1)) begin
                    state_d    = RESP;
                    wcnt_d     = '0;
                    enter_resp = 1'b1;
                end else begin
                    wcnt_d = wcnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (enter_resp) begin
            if (acc_oob) fault_d = 1'b1;
            if (acc_wstrb == 4'h0) rdata_d = acc_oob ? FAULT_RDATA : mem_q[acc_idx];
        end
    end

    always_comb begin
        rd_d = rd_q;
        wr_d = wr_q;
        if_d = if_q;
        if (state_q == RESP) begin
            if (instr_q)               if_d = sat_inc(if_q);
            else if (wstrb_q == 4'h0)  rd_d = sat_inc(rd_q);
            else                       wr_d = sat_inc(wr_q);
        end
    end

    // While reset is held state_q reads IDLE, so a live mem_valid could mimic a zero-wait accept.
    assign ram_we = enter_resp && resetn && !acc_oob && (acc_wstrb != 4'h0);

    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wstrb[i]) mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            instr_q <= 1'b0;
            rdata_q <= '0;
            fault_q <= 1'b0;
            rd_q    <= '0;
            wr_q    <= '0;
            if_q    <= '0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            instr_q <= instr_d;
            rdata_q <= rdata_d;
            fault_q <= fault_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            if_q    <= if_d;
        end
    end

    assign mem_ready = (state_q == RESP);
    assign mem_rdata = rdata_q;
    assign fault     = fault_q;
    assign rd_count  = rd_q;
    assign wr_count  = wr_q;
    assign if_count  = if_q;

endmodule

// File: tb/tb_picorv32_mem_responder.sv
// Directed bench for picorv32_mem_responder: three instances with wait states 1, 0 and 3.
`timescale 1ns/1ps
module tb_picorv32_mem_responder;

    typedef struct packed {
        logic        valid;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } req_t;

    typedef struct {
        int          d;
        logic        instr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          nrd;
        int          nwr;
        int          nif;
        logic        flt;
    } vec_t;

    localparam logic [2:0][3:0] WC = {4'd3, 4'd0, 4'd1};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    req_t [2:0]        req;
    logic [2:0]        rstn, rdy, flt;
    logic [2:0][31:0]  rdata;
    logic [2:0][15:0]  rdc, wrc, ifc;
    logic [3:0]        rdc2, wrc2, ifc2;
    int                nvec = 0;
    int                nmis = 0;

    assign rdc[2] = {12'h0, rdc2};
    assign wrc[2] = {12'h0, wrc2};
    assign ifc[2] = {12'h0, ifc2};

    picorv32_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(1), .CNT_W(16)) u_dut0 (
        .clk(clk), .resetn(rstn[0]), .mem_valid(req[0].valid), .mem_instr(req[0].instr),
        .mem_addr(req[0].addr), .mem_wdata(req[0].wdata), .mem_wstrb(req[0].wstrb),
        .mem_ready(rdy[0]), .mem_rdata(rdata[0]), .fault(flt[0]),
        .rd_count(rdc[0]), .wr_count(wrc[0]), .if_count(ifc[0]));

    picorv32_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0), .CNT_W(16)) u_dut1 (
        .clk(clk), .resetn(rstn[1]), .mem_valid(req[1].valid), .mem_instr(req[1].instr),
        .mem_addr(req[1].addr), .mem_wdata(req[1].wdata), .mem_wstrb(req[1].wstrb),
        .mem_ready(rdy[1]), .mem_rdata(rdata[1]), .fault(flt[1]),
        .rd_count(rdc[1]), .wr_count(wrc[1]), .if_count(ifc[1]));

    picorv32_mem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(3), .CNT_W(4)) u_dut2 (
        .clk(clk), .resetn(rstn[2]), .mem_valid(req[2].valid), .mem_instr(req[2].instr),
        .mem_addr(req[2].addr), .mem_wdata(req[2].wdata), .mem_wstrb(req[2].wstrb),
        .mem_ready(rdy[2]), .mem_rdata(rdata[2]), .fault(flt[2]),
        .rd_count(rdc2), .wr_count(wrc2), .if_count(ifc2));

`ifdef MEM_RESP_LFSR_WAIT_EN
    logic [2:0][15:0] mdl;
`endif

    task automatic seed(input int d);
`ifdef MEM_RESP_LFSR_WAIT_EN
        mdl[d] = 16'hACE1;
`endif
    endtask

    // Expected latency of the next accepted request; advances the reference LFSR.
    task automatic exp_lat(input int d, output int l);
        l = int'(WC[d]) + 1;
`ifdef MEM_RESP_LFSR_WAIT_EN
        l = l + int'(mdl[d][1:0]);
        mdl[d] = {mdl[d][0] ^ mdl[d][2] ^ mdl[d][3] ^ mdl[d][5], mdl[d][15:1]};
`endif
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d, input logic ins, input logic [31:0] a,
                                input logic [31:0] w, input logic [3:0] s, input logic [31:0] r,
                                input int nr, input int nw, input int ni, input logic f);
        vec_t v;
        v.d = d; v.instr = ins; v.addr = a; v.wdata = w; v.wstrb = s;
        v.rdata = r; v.nrd = nr; v.nwr = nw; v.nif = ni; v.flt = f;
        return v;
    endfunction

    // One handshake: latency counts posedges from acceptance to the first mem_ready (-1 on timeout).
    task automatic txn(input int d, input logic instr, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, output int lat, output logic [31:0] rd, output logic late);
        @(posedge clk); #1;
        req[d] = '{valid: 1'b1, instr: instr, addr: addr, wdata: wdata, wstrb: wstrb};
        lat = -1;
        rd  = 32'h0;
        for (int k = 1; k <= 32; k++) begin
            @(posedge clk); @(negedge clk);
            if (rdy[d]) begin
                lat = k;
                rd  = rdata[d];
                break;
            end
        end
        @(posedge clk); #1;
        req[d].valid = 1'b0;
        @(negedge clk);
        late = rdy[d];
    endtask

    task automatic chk_cnt(input string nm, input int d, input int nr, input int nw, input int ni, input logic f);
        chk({nm, " rd_count"}, {16'h0, rdc[d]}, 32'(nr));
        chk({nm, " wr_count"}, {16'h0, wrc[d]}, 32'(nw));
        chk({nm, " if_count"}, {16'h0, ifc[d]}, 32'(ni));
        chk({nm, " fault"}, {31'h0, flt[d]}, {31'h0, f});
    endtask

    initial begin
        vec_t        vt[18];
        int          lat, el;
        logic [31:0] rd;
        logic        late, seen;

        req  = '0;
        rstn = '0;
        for (int d = 0; d < 3; d++) seed(d);

        vt[0]  = mk(0, 0, 32'h10,       32'h12345678, 4'hF, 32'h0,        0, 1, 0, 0);
        vt[1]  = mk(0, 0, 32'h10,       32'h0,        4'h0, 32'h12345678, 1, 1, 0, 0);
        vt[2]  = mk(0, 0, 32'h10,       32'h0000AB00, 4'h2, 32'h12345678, 1, 2, 0, 0);
        vt[3]  = mk(0, 0, 32'h10,       32'h0,        4'h0, 32'h1234AB78, 2, 2, 0, 0);
        vt[4]  = mk(0, 0, 32'h14,       32'hCAFEF00D, 4'hF, 32'h1234AB78, 2, 3, 0, 0);
        vt[5]  = mk(0, 0, 32'h14,       32'h0,        4'h0, 32'hCAFEF00D, 3, 3, 0, 0);
        vt[6]  = mk(0, 0, 32'h0,        32'h5A5A5A5A, 4'hF, 32'hCAFEF00D, 3, 4, 0, 0);
        vt[7]  = mk(0, 0, 32'hFFC,      32'h0BADF00D, 4'hF, 32'hCAFEF00D, 3, 5, 0, 0);
        vt[8]  = mk(0, 0, 32'hFFC,      32'h0,        4'h0, 32'h0BADF00D, 4, 5, 0, 0);
        vt[9]  = mk(0, 0, 32'h10,       32'h0,        4'h0, 32'h1234AB78, 5, 5, 0, 0);
        vt[10] = mk(1, 0, 32'h0,        32'h00000013, 4'hF, 32'h0,        0, 1, 0, 0);
        vt[11] = mk(1, 1, 32'h0,        32'h0,        4'h0, 32'h00000013, 0, 1, 1, 0);
        vt[12] = mk(1, 0, 32'h0,        32'h0,        4'h0, 32'h00000013, 1, 1, 1, 0);
        vt[13] = mk(0, 0, 32'h1000,     32'h0,        4'h0, 32'hDEADBEEF, 6, 5, 0, 1);
        vt[14] = mk(0, 0, 32'h1000,     32'h11111111, 4'hF, 32'hDEADBEEF, 6, 6, 0, 1);
        vt[15] = mk(0, 0, 32'h0,        32'h0,        4'h0, 32'h5A5A5A5A, 7, 6, 0, 1);
        vt[16] = mk(0, 0, 32'hFFFFFFFC, 32'h0,        4'h0, 32'hDEADBEEF, 8, 6, 0, 1);
        vt[17] = mk(0, 1, 32'h10,       32'h0,        4'h0, 32'h1234AB78, 8, 6, 1, 1);

        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 3'b111;
        @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("reset%0d mem_ready", d), {31'h0, rdy[d]}, 32'h0);
            chk($sformatf("reset%0d mem_rdata", d), rdata[d], 32'h0);
            chk_cnt($sformatf("reset%0d", d), d, 0, 0, 0, 1'b0);
        end

        for (int i = 0; i < 18; i++) begin
            exp_lat(vt[i].d, el);
            txn(vt[i].d, vt[i].instr, vt[i].addr, vt[i].wdata, vt[i].wstrb, lat, rd, late);
            chk($sformatf("v%0d latency", i), 32'(lat), 32'(el));
            chk($sformatf("v%0d mem_rdata", i), rd, vt[i].rdata);
            chk($sformatf("v%0d ready_after", i), {31'h0, late}, 32'h0);
            chk_cnt($sformatf("v%0d", i), vt[i].d, vt[i].nrd, vt[i].nwr, vt[i].nif, vt[i].flt);
        end

        // Fault stays set across a run of clean reads.
        for (int i = 0; i < 20; i++) begin
            exp_lat(0, el);
            txn(0, 1'b0, 32'h14, 32'h0, 4'h0, lat, rd, late);
            chk($sformatf("sticky%0d mem_rdata", i), rd, 32'hCAFEF00D);
        end
        chk_cnt("sticky", 0, 28, 6, 1, 1'b1);

        // Abort: mem_valid dropped while waiting.
        exp_lat(2, el);
        txn(2, 1'b0, 32'h20, 32'h01020304, 4'hF, lat, rd, late);
        chk("w3 write latency", 32'(lat), 32'(el));
        exp_lat(2, el);
        @(posedge clk); #1;
        req[2] = '{valid: 1'b1, instr: 1'b0, addr: 32'h24, wdata: 32'h0, wstrb: 4'h0};
        @(posedge clk); #1;
        req[2].valid = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (rdy[2]) seen = 1'b1;
        end
        chk("abort ready_seen", {31'h0, seen}, 32'h0);
        chk_cnt("abort", 2, 0, 1, 0, 1'b1);

        // Reset pulsed while a write is waiting: RAM word must keep its old value.
        @(posedge clk); #1;
        req[2] = '{valid: 1'b1, instr: 1'b0, addr: 32'h20, wdata: 32'hFFFFFFFF, wstrb: 4'hF};
        @(posedge clk); #2;
        rstn[2] = 1'b0;
        req[2].valid = 1'b0;
        #1;
        chk("rstwait mem_ready", {31'h0, rdy[2]}, 32'h0);
        repeat (5) @(negedge clk);
        rstn[2] = 1'b1;
        seed(2);
        @(negedge clk);
        chk_cnt("rstwait", 2, 0, 0, 0, 1'b0);
        exp_lat(2, el);
        txn(2, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, late);
        chk("rstwait readback", rd, 32'h01020304);
        chk("rstwait latency", 32'(lat), 32'(el));

        // Reset during RESP must drop mem_ready without waiting for a clock edge.
        exp_lat(2, el);
        @(posedge clk); #1;
        req[2] = '{valid: 1'b1, instr: 1'b0, addr: 32'h20, wdata: 32'h0, wstrb: 4'h0};
        seen = 1'b0;
        for (int k = 0; k < 32 && !seen; k++) begin
            @(negedge clk);
            seen = rdy[2];
        end
        chk("rstresp ready_seen", {31'h0, seen}, 32'h1);
        rstn[2] = 1'b0;
        req[2].valid = 1'b0;
        #1;
        chk("rstresp mem_ready", {31'h0, rdy[2]}, 32'h0);
        chk("rstresp rd_count", {16'h0, rdc[2]}, 32'h0);
        @(negedge clk);
        rstn[2] = 1'b1;
        seed(2);

        // Saturation of the narrow counter instance.
        for (int i = 0; i < 20; i++) begin
            exp_lat(2, el);
            txn(2, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, late);
        end
        chk_cnt("saturate", 2, 15, 0, 0, 1'b0);

        // Reset clears fault; then a long read run checks latency against the reference LFSR.
        @(negedge clk);
        rstn[0] = 1'b0;
        @(negedge clk);
        rstn[0] = 1'b1;
        seed(0);
        @(negedge clk);
        chk_cnt("rst0", 0, 0, 0, 0, 1'b0);
        for (int i = 0; i < 100; i++) begin
            exp_lat(0, el);
            txn(0, 1'b0, 32'h10, 32'h0, 4'h0, lat, rd, late);
            chk($sformatf("run%0d latency", i), 32'(lat), 32'(el));
            chk($sformatf("run%0d mem_rdata", i), rd, 32'h1234AB78);
`ifdef MEM_RESP_LFSR_WAIT_EN
            chk($sformatf("run%0d lat_range", i), {31'h0, (lat >= 2 && lat <= 5)}, 32'h1);
`endif
        end
        chk_cnt("run", 0, 100, 0, 0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
